// File: rtl/mem_arbiter_if.sv
// Pulse-based memory request/response bundle shared by the requesters and the bus port.
// master issues requests and receives responses; slave is the side that answers them.
interface mem_arbiter_if;
  logic        request_enable;
  logic        mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        response_enable;
  logic [31:0] data;

  modport master (
    output request_enable, mode, addr, wdata, wstrb,
    input  response_enable, data
  );

  modport slave (
    input  request_enable, mode, addr, wdata, wstrb,
    output response_enable, data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one pulse-based memory bus between fetch (f) and load/store (m) ports.
// Define ARBITER_RR_EN for round-robin; otherwise fixed priority with m winning conflicts.
module mem_arbiter (
  input  logic          clk,
  input  logic          rstn,
  mem_arbiter_if.slave  f,
  mem_arbiter_if.slave  m,
  mem_arbiter_if.master bus
);

  typedef struct packed {
    logic        valid;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } pend_t;

  typedef enum logic [0:0] {StIdle, StWait} state_e;
  typedef enum logic [0:0] {PortF, PortM} port_e;

  state_e      state_q, state_d;
  port_e       owner_q, owner_d;
  port_e       winner;
  pend_t       f_pend_q, f_pend_d, m_pend_q, m_pend_d;
  pend_t       f_pulse, m_pulse, f_cand, m_cand, win;
  logic        grant;
  logic        req_q, req_d, mode_q, mode_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        f_resp_q, f_resp_d, m_resp_q, m_resp_d;
  logic [31:0] f_data_q, f_data_d, m_data_q, m_data_d;
`ifdef ARBITER_RR_EN
  port_e       last_q, last_d;
`endif

  assign f_pulse = '{valid: f.request_enable, mode: f.mode, addr: f.addr,
                     wdata: f.wdata, wstrb: f.wstrb};
  assign m_pulse = '{valid: m.request_enable, mode: m.mode, addr: m.addr,
                     wdata: m.wdata, wstrb: m.wstrb};
  // A buffered request takes precedence over a same-cycle pulse (which is then a violation).
  assign f_cand  = f_pend_q.valid ? f_pend_q : f_pulse;
  assign m_cand  = m_pend_q.valid ? m_pend_q : m_pulse;
  assign grant   = (state_q == StIdle) && (f_cand.valid || m_cand.valid);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= StIdle;
      owner_q  <= PortF;
      f_pend_q <= '0;
      m_pend_q <= '0;
      req_q    <= 1'b0;
      mode_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      f_resp_q <= 1'b0;
      f_data_q <= '0;
      m_resp_q <= 1'b0;
      m_data_q <= '0;
`ifdef ARBITER_RR_EN
      last_q   <= PortM;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      f_pend_q <= f_pend_d;
      m_pend_q <= m_pend_d;
      req_q    <= req_d;
      mode_q   <= mode_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      f_resp_q <= f_resp_d;
      f_data_q <= f_data_d;
      m_resp_q <= m_resp_d;
      m_data_q <= m_data_d;
`ifdef ARBITER_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StWait;
      StWait:  if (bus.response_enable) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    winner = PortM;
    if (f_cand.valid && m_cand.valid) begin
`ifdef ARBITER_RR_EN
      winner = (last_q == PortM) ? PortF : PortM;
`else
      winner = PortM;
`endif
    end else if (f_cand.valid) begin
      winner = PortF;
    end
    win = (winner == PortM) ? m_cand : f_cand;
  end

  always_comb begin
    f_pend_d = f_pend_q;
    m_pend_d = m_pend_q;
    owner_d  = owner_q;
    req_d    = 1'b0;
    mode_d   = mode_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    f_resp_d = 1'b0;
    f_data_d = f_data_q;
    m_resp_d = 1'b0;
    m_data_d = m_data_q;
`ifdef ARBITER_RR_EN
    last_d   = last_q;
`endif
    // Pulses into a full buffer, or from the port owning the bus, are dropped.
    if (f.request_enable && !f_pend_q.valid && !(state_q == StWait && owner_q == PortF)) begin
      f_pend_d = f_pulse;
    end
    if (m.request_enable && !m_pend_q.valid && !(state_q == StWait && owner_q == PortM)) begin
      m_pend_d = m_pulse;
    end
    if (grant) begin
      req_d   = 1'b1;
      mode_d  = win.mode;
      addr_d  = win.addr;
      wdata_d = win.wdata;
      wstrb_d = win.wstrb;
      owner_d = winner;
`ifdef ARBITER_RR_EN
      last_d  = winner;
`endif
      if (winner == PortM) m_pend_d = '0;
      else                 f_pend_d = '0;
    end
    if (state_q == StWait && bus.response_enable) begin
      if (owner_q == PortM) begin
        m_resp_d = 1'b1;
        m_data_d = bus.data;
      end else begin
        f_resp_d = 1'b1;
        f_data_d = bus.data;
      end
    end
  end

  assign bus.request_enable = req_q;
  assign bus.mode           = mode_q;
  assign bus.addr           = addr_q;
  assign bus.wdata          = wdata_q;
  assign bus.wstrb          = wstrb_q;
  assign f.response_enable  = f_resp_q;
  assign f.data             = f_data_q;
  assign m.response_enable  = m_resp_q;
  assign m.data             = m_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; inputs change and outputs are sampled 1 time
// unit after each rising edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if f_if ();
  mem_arbiter_if m_if ();
  mem_arbiter_if bus_if ();

  mem_arbiter dut (
    .clk  (clk),
    .rstn (rstn),
    .f    (f_if),
    .m    (m_if),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    f_if.request_enable   = 1'b0;
    f_if.mode             = 1'b0;
    f_if.addr             = '0;
    f_if.wdata            = '0;
    f_if.wstrb            = '0;
    m_if.request_enable   = 1'b0;
    m_if.mode             = 1'b0;
    m_if.addr             = '0;
    m_if.wdata            = '0;
    m_if.wstrb            = '0;
    bus_if.response_enable = 1'b0;
    bus_if.data           = '0;
  endtask

  task automatic bus_respond(input logic [31:0] d);
    bus_if.response_enable = 1'b1;
    bus_if.data            = d;
    step();
    bus_if.response_enable = 1'b0;
    bus_if.data            = '0;
  endtask

  task automatic test_reset();
    logic [137:0] outs;
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    outs = {bus_if.request_enable, bus_if.mode, bus_if.addr, bus_if.wdata, bus_if.wstrb,
            f_if.response_enable, f_if.data, m_if.response_enable, m_if.data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", outs);
    end
  endtask

  task automatic test_single_fetch();
    f_if.request_enable = 1'b1;
    f_if.mode           = 1'b0;
    f_if.addr           = 32'h100;
    step();
    f_if.request_enable = 1'b0;
    f_if.addr           = 32'h0;
    checks++;
    if (bus_if.request_enable !== 1'b1 || bus_if.addr !== 32'h100 || bus_if.mode !== 1'b0) begin
      errors++;
      $display("FAIL fetch_grant got req=%b addr=%h mode=%b expected req=1 addr=100 mode=0",
               bus_if.request_enable, bus_if.addr, bus_if.mode);
    end
    step();
    checks++;
    if (bus_if.request_enable !== 1'b0 || bus_if.addr !== 32'h100) begin
      errors++;
      $display("FAIL fetch_req_pulse got req=%b addr=%h expected req=0 addr=100",
               bus_if.request_enable, bus_if.addr);
    end
    step();
    bus_respond(32'hDEADBEEF);
    checks++;
    if (f_if.response_enable !== 1'b1 || f_if.data !== 32'hDEADBEEF ||
        m_if.response_enable !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp got f_resp=%b f_data=%h m_resp=%b expected 1 deadbeef 0",
               f_if.response_enable, f_if.data, m_if.response_enable);
    end
    step();
    checks++;
    if (f_if.response_enable !== 1'b0 || f_if.data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL fetch_resp_hold got f_resp=%b f_data=%h expected 0 deadbeef",
               f_if.response_enable, f_if.data);
    end
  endtask

`ifndef ARBITER_RR_EN
  task automatic test_fixed_priority();
    f_if.request_enable = 1'b1;
    f_if.mode           = 1'b0;
    f_if.addr           = 32'h200;
    m_if.request_enable = 1'b1;
    m_if.mode           = 1'b1;
    m_if.addr           = 32'h3000;
    m_if.wdata          = 32'h55;
    m_if.wstrb          = 4'h1;
    step();
    clear_inputs();
    checks++;
    if (bus_if.request_enable !== 1'b1 || bus_if.addr !== 32'h3000 || bus_if.mode !== 1'b1 ||
        bus_if.wdata !== 32'h55 || bus_if.wstrb !== 4'h1) begin
      errors++;
      $display("FAIL prio_m_first got req=%b addr=%h mode=%b wdata=%h wstrb=%h expected 1 3000 1 55 1",
               bus_if.request_enable, bus_if.addr, bus_if.mode, bus_if.wdata, bus_if.wstrb);
    end
    step();
    step();
    bus_respond(32'h1111);
    checks++;
    if (m_if.response_enable !== 1'b1 || m_if.data !== 32'h1111 ||
        bus_if.request_enable !== 1'b0 || f_if.response_enable !== 1'b0) begin
      errors++;
      $display("FAIL prio_m_resp got m_resp=%b m_data=%h req=%b f_resp=%b expected 1 1111 0 0",
               m_if.response_enable, m_if.data, bus_if.request_enable, f_if.response_enable);
    end
    step();
    checks++;
    if (bus_if.request_enable !== 1'b1 || bus_if.addr !== 32'h200 || bus_if.mode !== 1'b0) begin
      errors++;
      $display("FAIL prio_f_second got req=%b addr=%h mode=%b expected 1 200 0",
               bus_if.request_enable, bus_if.addr, bus_if.mode);
    end
    step();
    bus_respond(32'h2222);
    checks++;
    if (f_if.response_enable !== 1'b1 || f_if.data !== 32'h2222) begin
      errors++;
      $display("FAIL prio_f_resp got f_resp=%b f_data=%h expected 1 2222",
               f_if.response_enable, f_if.data);
    end
    step();
  endtask
`else
  task automatic test_round_robin();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    for (int r = 0; r < 2; r++) begin
      f_if.request_enable = 1'b1;
      f_if.addr           = 32'h10 + r;
      m_if.request_enable = 1'b1;
      m_if.addr           = 32'h20 + r;
      step();
      clear_inputs();
      checks++;
      if (bus_if.request_enable !== 1'b1 || bus_if.addr !== 32'h10 + r) begin
        errors++;
        $display("FAIL rr_f_grant round %0d got req=%b addr=%h expected 1 %h",
                 r, bus_if.request_enable, bus_if.addr, 32'h10 + r);
      end
      step();
      bus_respond(32'hF0 + r);
      step();
      checks++;
      if (bus_if.request_enable !== 1'b1 || bus_if.addr !== 32'h20 + r) begin
        errors++;
        $display("FAIL rr_m_grant round %0d got req=%b addr=%h expected 1 %h",
                 r, bus_if.request_enable, bus_if.addr, 32'h20 + r);
      end
      step();
      bus_respond(32'hA0 + r);
      checks++;
      if (m_if.response_enable !== 1'b1 || m_if.data !== 32'hA0 + r) begin
        errors++;
        $display("FAIL rr_m_resp round %0d got m_resp=%b m_data=%h", r,
                 m_if.response_enable, m_if.data);
      end
      step();
    end
  endtask
`endif

  task automatic test_pulse_during_wait();
    int extra_req = 0;
    f_if.request_enable = 1'b1;
    f_if.addr           = 32'h400;
    step();
    f_if.request_enable = 1'b0;
    m_if.request_enable = 1'b1;
    m_if.mode           = 1'b1;
    m_if.addr           = 32'h500;
    m_if.wdata          = 32'hAA;
    m_if.wstrb          = 4'hF;
    step();
    m_if.request_enable = 1'b0;
    m_if.mode           = 1'b0;
    m_if.addr           = 32'h999;
    m_if.wdata          = 32'h0;
    m_if.wstrb          = 4'h0;
    for (int i = 0; i < 3; i++) begin
      if (bus_if.request_enable) extra_req++;
      step();
    end
    bus_respond(32'h4444);
    if (bus_if.request_enable) extra_req++;
    checks++;
    if (extra_req != 0 || f_if.response_enable !== 1'b1 || f_if.data !== 32'h4444) begin
      errors++;
      $display("FAIL wait_hold got extra_req=%0d f_resp=%b f_data=%h expected 0 1 4444",
               extra_req, f_if.response_enable, f_if.data);
    end
    step();
    checks++;
    if (bus_if.request_enable !== 1'b1 || bus_if.addr !== 32'h500 || bus_if.mode !== 1'b1 ||
        bus_if.wdata !== 32'hAA || bus_if.wstrb !== 4'hF) begin
      errors++;
      $display("FAIL wait_latched_m got req=%b addr=%h mode=%b wdata=%h wstrb=%h expected 1 500 1 aa f",
               bus_if.request_enable, bus_if.addr, bus_if.mode, bus_if.wdata, bus_if.wstrb);
    end
    step();
    bus_respond(32'h5555);
    checks++;
    if (m_if.response_enable !== 1'b1 || m_if.data !== 32'h5555) begin
      errors++;
      $display("FAIL wait_m_resp got m_resp=%b m_data=%h expected 1 5555",
               m_if.response_enable, m_if.data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [137:0] outs;
    int           resp_seen = 0;
    f_if.request_enable = 1'b1;
    f_if.addr           = 32'h600;
    f_if.mode           = 1'b1;
    f_if.wdata          = 32'h12;
    f_if.wstrb          = 4'h3;
    step();
    clear_inputs();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    outs = {bus_if.request_enable, bus_if.mode, bus_if.addr, bus_if.wdata, bus_if.wstrb,
            f_if.response_enable, f_if.data, m_if.response_enable, m_if.data};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %h expected 0", outs);
    end
    step();
    bus_respond(32'h7777);
    for (int i = 0; i < 2; i++) begin
      if (f_if.response_enable || m_if.response_enable) resp_seen++;
      step();
    end
    checks++;
    if (resp_seen != 0 || f_if.data !== 32'h0 || bus_if.request_enable !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_resp got resp_seen=%0d f_data=%h req=%b expected 0 0 0",
               resp_seen, f_if.data, bus_if.request_enable);
    end
  endtask

  task automatic test_spurious();
    bus_respond(32'h8888);
    checks++;
    if (f_if.response_enable !== 1'b0 || m_if.response_enable !== 1'b0 ||
        bus_if.request_enable !== 1'b0) begin
      errors++;
      $display("FAIL spurious_resp got f_resp=%b m_resp=%b req=%b expected 0 0 0",
               f_if.response_enable, m_if.response_enable, bus_if.request_enable);
    end
    f_if.request_enable = 1'b1;
    f_if.addr           = 32'h700;
    step();
    clear_inputs();
    checks++;
    if (bus_if.request_enable !== 1'b1 || bus_if.addr !== 32'h700) begin
      errors++;
      $display("FAIL spurious_still_idle got req=%b addr=%h expected 1 700",
               bus_if.request_enable, bus_if.addr);
    end
    step();
    bus_respond(32'h9999);
    checks++;
    if (f_if.response_enable !== 1'b1 || f_if.data !== 32'h9999) begin
      errors++;
      $display("FAIL spurious_followup got f_resp=%b f_data=%h expected 1 9999",
               f_if.response_enable, f_if.data);
    end
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    step();
    test_single_fetch();
`ifndef ARBITER_RR_EN
    test_fixed_priority();
`else
    test_round_robin();
`endif
    test_pulse_during_wait();
    test_reset_mid();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
